canvas_commit_reader: RTL and testbench



---
 rtl/canvas_commit_reader_pkg.sv | 17 +
 rtl/canvas_commit_reader_if.sv | 32 +++
 rtl/canvas_commit_reader_valid_delay_line.sv | 24 ++
 rtl/canvas_commit_reader.sv | 128 ++++++++++++
 tb/tb_canvas_commit_reader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/canvas_commit_reader_pkg.sv
// Shared constants and state encoding for the canvas commit reader.
package canvas_commit_reader_pkg;

  localparam int TILE_DIM          = 32;
  localparam int CANVAS_ADDR_W     = 10;
  localparam int TILE_STORE_ADDR_W = 15;
  localparam int INK_W             = 11;
  localparam int ROW_IDX_W         = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/canvas_commit_reader_if.sv
// Bundle of the writer handshake, canvas RAM read port and tile store write port.
// The master side is the commit reader; the slave side is its surroundings.
interface canvas_commit_reader_if;
  import canvas_commit_reader_pkg::*;

  logic                         commit;
  logic                         editing;
  logic [ROW_IDX_W-1:0]         tile_x;
  logic [ROW_IDX_W-1:0]         tile_y;
  logic                         rd_en;
  logic [CANVAS_ADDR_W-1:0]     rd_addr;
  logic                         rd_data;
  logic                         row_wr_en;
  logic [TILE_STORE_ADDR_W-1:0] row_wr_addr;
  logic [TILE_DIM-1:0]          row_wr_data;
  logic                         busy;
  logic                         end_of_editing;
  logic [INK_W-1:0]             ink_count;

  modport master (
    input  commit, editing, tile_x, tile_y, rd_data,
    output rd_en, rd_addr, row_wr_en, row_wr_addr, row_wr_data,
           busy, end_of_editing, ink_count
  );

  modport slave (
    output commit, editing, tile_x, tile_y, rd_data,
    input  rd_en, rd_addr, row_wr_en, row_wr_addr, row_wr_data,
           busy, end_of_editing, ink_count
  );

endinterface

// File: rtl/canvas_commit_reader_valid_delay_line.sv
// DEPTH-stage 1-bit delay line; marks when a read issued DEPTH cycles ago returns data.
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stages;

  // Shift the strobe one stage per clock; a reset drops every in-flight strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= (stages << 1) | DEPTH'(din);
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/canvas_commit_reader.sv
// Commit reader: scans the 32x32 canvas, packs rows into words, writes them to
// the tile store at the edited tile, counts ink and signals end of editing.
module canvas_commit_reader
  import canvas_commit_reader_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  canvas_commit_reader_if.master bus
);

  localparam logic [CANVAS_ADDR_W-1:0] LAST_ADDR = CANVAS_ADDR_W'(TILE_DIM * TILE_DIM - 1);
  localparam logic [ROW_IDX_W-1:0]     LAST_IDX  = ROW_IDX_W'(TILE_DIM - 1);

  state_t               state;
  logic [ROW_IDX_W-1:0] tx;
  logic [ROW_IDX_W-1:0] ty;
  logic [ROW_IDX_W-1:0] col;
  logic [ROW_IDX_W-1:0] row;
  logic [TILE_DIM-1:0]  row_sr;
  logic [TILE_DIM-1:0]  next_row;
  logic [INK_W-1:0]     acc;
  logic                 rd_valid;
  logic                 accept;
  logic                 last_sample;

  valid_delay_line #(
    .DEPTH (RD_LATENCY)
  ) u_valid_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.rd_en),
    .dout  (rd_valid)
  );

  assign accept      = (state == IDLE) && bus.commit && bus.editing;
  assign last_sample = rd_valid && (col == LAST_IDX) && (row == LAST_IDX);

  // Current row with the incoming pixel merged in at its column.
  always_comb begin
    next_row      = row_sr;
    next_row[col] = bus.rd_data;
  end

  // Control FSM: issue 1024 back-to-back reads, wait for the last row, then pulse completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      tx                 <= '0;
      ty                 <= '0;
      bus.rd_en          <= 1'b0;
      bus.rd_addr        <= '0;
      bus.busy           <= 1'b0;
      bus.end_of_editing <= 1'b0;
      bus.ink_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx          <= bus.tile_x;
            ty          <= bus.tile_y;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= '0;
            bus.busy    <= 1'b1;
            state       <= READ;
          end
        end
        READ: begin
          if (bus.rd_addr == LAST_ADDR) begin
            bus.rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            bus.rd_addr <= bus.rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (last_sample) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!bus.end_of_editing) begin
            bus.end_of_editing <= 1'b1;
            bus.busy           <= 1'b0;
            bus.ink_count      <= acc;
          end else begin
            bus.end_of_editing <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: collect valid pixels into rows, count ink, emit each finished row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col             <= '0;
      row             <= '0;
      row_sr          <= '0;
      acc             <= '0;
      bus.row_wr_en   <= 1'b0;
      bus.row_wr_addr <= '0;
      bus.row_wr_data <= '0;
    end else begin
      bus.row_wr_en <= 1'b0;
      if (accept) begin
        col    <= '0;
        row    <= '0;
        row_sr <= '0;
        acc    <= '0;
      end else if (rd_valid) begin
        row_sr <= next_row;
        col    <= col + 1'b1;
        acc    <= acc + INK_W'(bus.rd_data);
        if (col == LAST_IDX) begin
          bus.row_wr_en   <= 1'b1;
          bus.row_wr_addr <= {ty, tx, row};
          bus.row_wr_data <= next_row;
          row             <= row + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_canvas_commit_reader.sv
// Bench for canvas_commit_reader: three instances (read latency 1, 2, 3) run
// side by side against one canvas model with matching read latencies.
// Observation at the negedge after posedge k shows the value for cycle k+1.
module tb_canvas_commit_reader;
  import canvas_commit_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       commit;
  logic       editing;
  logic [4:0] tile_x;
  logic [4:0] tile_y;
  int         cyc = 0;

  always #5 clk = ~clk;

  // Posedge counter used as the cycle reference.
  always @(posedge clk) cyc <= cyc + 1;

  canvas_commit_reader_if b1 ();
  canvas_commit_reader_if b2 ();
  canvas_commit_reader_if b3 ();

  canvas_commit_reader #(.RD_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  canvas_commit_reader #(.RD_LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  canvas_commit_reader #(.RD_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  logic        rd_en_v   [3];
  logic [9:0]  rd_addr_v [3];
  logic        wr_en_v   [3];
  logic [14:0] wr_addr_v [3];
  logic [31:0] wr_data_v [3];
  logic        busy_v    [3];
  logic        eoe_v     [3];
  logic [10:0] ink_v     [3];
  logic        ram_q     [3];

  assign b1.commit = commit;  assign b1.editing = editing;
  assign b1.tile_x = tile_x;  assign b1.tile_y  = tile_y;   assign b1.rd_data = ram_q[0];
  assign b2.commit = commit;  assign b2.editing = editing;
  assign b2.tile_x = tile_x;  assign b2.tile_y  = tile_y;   assign b2.rd_data = ram_q[1];
  assign b3.commit = commit;  assign b3.editing = editing;
  assign b3.tile_x = tile_x;  assign b3.tile_y  = tile_y;   assign b3.rd_data = ram_q[2];

  assign rd_en_v[0] = b1.rd_en;  assign rd_addr_v[0] = b1.rd_addr;  assign wr_en_v[0] = b1.row_wr_en;
  assign rd_en_v[1] = b2.rd_en;  assign rd_addr_v[1] = b2.rd_addr;  assign wr_en_v[1] = b2.row_wr_en;
  assign rd_en_v[2] = b3.rd_en;  assign rd_addr_v[2] = b3.rd_addr;  assign wr_en_v[2] = b3.row_wr_en;
  assign wr_addr_v[0] = b1.row_wr_addr;  assign wr_data_v[0] = b1.row_wr_data;
  assign wr_addr_v[1] = b2.row_wr_addr;  assign wr_data_v[1] = b2.row_wr_data;
  assign wr_addr_v[2] = b3.row_wr_addr;  assign wr_data_v[2] = b3.row_wr_data;
  assign busy_v[0] = b1.busy;  assign eoe_v[0] = b1.end_of_editing;  assign ink_v[0] = b1.ink_count;
  assign busy_v[1] = b2.busy;  assign eoe_v[1] = b2.end_of_editing;  assign ink_v[1] = b2.ink_count;
  assign busy_v[2] = b3.busy;  assign eoe_v[2] = b3.end_of_editing;  assign ink_v[2] = b3.ink_count;

  // Canvas RAM model: one pipeline per instance, output tapped at that instance's latency.
  logic       canvas [1024];
  logic [2:0] pipe   [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pipe[i] <= {pipe[i][1:0], rd_en_v[i] ? canvas[rd_addr_v[i]] : 1'b0};
    end
  end

  assign ram_q[0] = pipe[0][0];
  assign ram_q[1] = pipe[1][1];
  assign ram_q[2] = pipe[2][2];

  int          checks   = 0;
  int          failures = 0;
  int          wr_cnt   [3];
  int          eoe_cnt  [3];
  int          eoe_cyc  [3];
  int          first_rd [3];
  int          rd_cnt   [3];
  int          busy_cnt [3];
  logic [14:0] addr_log [3][32];
  logic [31:0] data_log [3][32];
  int          t;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic e, input logic [4:0] x, input logic [4:0] y);
    commit  = c;
    editing = e;
    tile_x  = x;
    tile_y  = y;
  endtask

  task automatic clearLog();
    for (int i = 0; i < 3; i++) begin
      wr_cnt[i] = 0;  eoe_cnt[i] = 0;  eoe_cyc[i] = -1;
      first_rd[i] = -1;  rd_cnt[i] = 0;  busy_cnt[i] = 0;
      for (int r = 0; r < 32; r++) begin
        addr_log[i][r] = '0;
        data_log[i][r] = '0;
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (wr_en_v[i]) begin
        if (wr_cnt[i] < 32) begin
          addr_log[i][wr_cnt[i]] = wr_addr_v[i];
          data_log[i][wr_cnt[i]] = wr_data_v[i];
        end
        wr_cnt[i]++;
      end
      if (eoe_v[i]) begin
        eoe_cnt[i]++;
        eoe_cyc[i] = cyc;
      end
      if (rd_en_v[i]) begin
        if (rd_cnt[i] == 0) first_rd[i] = cyc;
        rd_cnt[i]++;
      end
      if (busy_v[i]) busy_cnt[i]++;
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  // Patterns: 0 = blank, 1 = diagonal pixel(x,x), 2 = all ink.
  task automatic fillCanvas(input int pattern);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        canvas[y * 32 + x] = (pattern == 2) || (pattern == 1 && x == y);
  endtask

  function automatic logic [31:0] expRow(input int pattern, input int r);
    case (pattern)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001 << r;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Pulse a commit; t becomes the cycle whose posedge accepted it.
  task automatic startCommit(input logic [4:0] x, input logic [4:0] y, output int ts);
    stepCycle();
    clearLog();
    applyStimulus(1'b1, 1'b1, x, y);
    stepCycle();
    ts = cyc;
    applyStimulus(1'b0, 1'b1, x, y);
  endtask

  task automatic checkScan(input string name, input int pattern, input int ts,
                           input logic [4:0] x, input logic [4:0] y, input logic [10:0] ink);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s_L%0d_rows", name, i + 1), 32'(wr_cnt[i]), 32'd32);
      checkOutput($sformatf("%s_L%0d_reads", name, i + 1), 32'(rd_cnt[i]), 32'd1024);
      checkOutput($sformatf("%s_L%0d_first_rd", name, i + 1), 32'(first_rd[i] - ts), 32'd0);
      checkOutput($sformatf("%s_L%0d_eoe_pulses", name, i + 1), 32'(eoe_cnt[i]), 32'd1);
      checkOutput($sformatf("%s_L%0d_eoe_time", name, i + 1), 32'(eoe_cyc[i] - ts), 32'(1025 + i + 1));
      checkOutput($sformatf("%s_L%0d_busy_cycles", name, i + 1), 32'(busy_cnt[i]), 32'(1025 + i + 1));
      checkOutput($sformatf("%s_L%0d_ink", name, i + 1), 32'(ink_v[i]), 32'(ink));
      checkOutput($sformatf("%s_L%0d_busy_end", name, i + 1), 32'(busy_v[i]), 32'd0);
      for (int r = 0; r < 32; r++) begin
        checkOutput($sformatf("%s_L%0d_row%0d_addr", name, i + 1, r),
                    32'(addr_log[i][r]), 32'(y) * 1024 + 32'(x) * 32 + 32'(r));
        checkOutput($sformatf("%s_L%0d_row%0d_data", name, i + 1, r),
                    data_log[i][r], expRow(pattern, r));
      end
    end
  endtask

  task automatic checkIdleOutputs(input string name);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s_L%0d_ctl", name, i + 1),
                  32'({rd_en_v[i], rd_addr_v[i], wr_en_v[i], busy_v[i], eoe_v[i], ink_v[i]}), 32'd0);
      checkOutput($sformatf("%s_L%0d_wr_addr", name, i + 1), 32'(wr_addr_v[i]), 32'd0);
      checkOutput($sformatf("%s_L%0d_wr_data", name, i + 1), wr_data_v[i], 32'd0);
    end
  endtask

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0);
    fillCanvas(0);
    clearLog();
    #3 rst_n = 1'b0;
    #1 checkIdleOutputs("reset");
    #20 rst_n = 1'b1;
    runCycles(3);

    fillCanvas(0);
    startCommit(5'd3, 5'd5, t);
    runCycles(1100);
    checkScan("zero", 0, t, 5'd3, 5'd5, 11'd0);

    fillCanvas(1);
    startCommit(5'd3, 5'd5, t);
    runCycles(1100);
    checkScan("diag", 1, t, 5'd3, 5'd5, 11'd32);

    fillCanvas(2);
    startCommit(5'd3, 5'd5, t);
    runCycles(1100);
    checkScan("ones", 2, t, 5'd3, 5'd5, 11'd1024);

    stepCycle();
    clearLog();
    applyStimulus(1'b1, 1'b0, 5'd3, 5'd5);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 5'd3, 5'd5);
    runCycles(2000);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("noedit_L%0d_reads", i + 1), 32'(rd_cnt[i]), 32'd0);
      checkOutput($sformatf("noedit_L%0d_busy", i + 1), 32'(busy_cnt[i]), 32'd0);
      checkOutput($sformatf("noedit_L%0d_eoe", i + 1), 32'(eoe_cnt[i]), 32'd0);
    end

    fillCanvas(1);
    startCommit(5'd3, 5'd5, t);
    runCycles(99);
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd5);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd5);
    runCycles(1000);
    checkScan("recommit", 1, t, 5'd3, 5'd5, 11'd32);

    fillCanvas(2);
    startCommit(5'd3, 5'd5, t);
    runCycles(330);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("prerst_L%0d_rows", i + 1), 32'(wr_cnt[i]), 32'd10);
    #2 rst_n = 1'b0;
    #1 checkIdleOutputs("midscan_reset");
    clearLog();
    runCycles(5);
    rst_n = 1'b1;
    runCycles(200);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("postrst_L%0d_rows", i + 1), 32'(wr_cnt[i]), 32'd0);
      checkOutput($sformatf("postrst_L%0d_eoe", i + 1), 32'(eoe_cnt[i]), 32'd0);
      checkOutput($sformatf("postrst_L%0d_busy", i + 1), 32'(busy_cnt[i]), 32'd0);
    end

    startCommit(5'd9, 5'd2, t);
    runCycles(1100);
    checkScan("fresh", 2, t, 5'd9, 5'd2, 11'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
